// File: rtl/alarm_time_keeper.sv
// Alarm clock time keeper: stores an editable alarm time, detects the rising
// edge of a current-time match and sequences ring / snooze / stop behaviour.
module alarm_time_keeper #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       hours,
   input  logic       mins,
   input  logic       alarm_en,
   input  logic       stop,
   input  logic       snooze,
   input  logic       sec_tick,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic [4:0] alarm_hour,
   output logic [5:0] alarm_min,
   output logic       ring,
   output logic       snoozing
);

   localparam int RING_W = $clog2(RING_SECS + 1);
   localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);

   localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
   localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
   localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
   localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
   localparam logic [RING_W-1:0] RING_ZERO = {RING_W{1'b0}};
   localparam logic [SNZ_W-1:0]  SNZ_ZERO  = {SNZ_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } state_t;

   state_t              state_r;
   logic [RING_W-1:0]   ring_cnt_r;
   logic [SNZ_W-1:0]    snz_cnt_r;
   logic                match_d_r;
   logic                match_s;
   logic                match_rise_s;
   logic                edit_s;

   // Current-time match, its rising edge, and any user edit of the alarm time
   always_comb begin
      match_s      = (cur_hour == alarm_hour) && (cur_min == alarm_min);
      match_rise_s = match_s && !match_d_r;
      edit_s       = hours || mins;
   end

   // Alarm time registers: independent hour and minute wrap, no carry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_hour <= 5'd0;
         alarm_min  <= 6'd0;
      end else begin
         if (hours) begin
            alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
         end else begin
            alarm_hour <= alarm_hour;
         end
         if (mins) begin
            alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
         end else begin
            alarm_min <= alarm_min;
         end
      end
   end

   // Match history; resets high so a time already equal at reset never rings
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         match_d_r <= 1'b1;
      end else begin
         match_d_r <= match_s;
      end
   end

   // Alarm FSM with registered ring/snoozing outputs and second counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         ring       <= 1'b0;
         snoozing   <= 1'b0;
         ring_cnt_r <= RING_ZERO;
         snz_cnt_r  <= SNZ_ZERO;
      end else if (!alarm_en) begin
         state_r    <= IDLE;
         ring       <= 1'b0;
         snoozing   <= 1'b0;
         ring_cnt_r <= RING_ZERO;
         snz_cnt_r  <= SNZ_ZERO;
      end else if (edit_s && ((state_r == RINGING) || (state_r == SNOOZE))) begin
         // editing the alarm cancels an active ring or snooze
         state_r    <= ARMED;
         ring       <= 1'b0;
         snoozing   <= 1'b0;
         ring_cnt_r <= RING_ZERO;
         snz_cnt_r  <= SNZ_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               state_r  <= ARMED;
               ring     <= 1'b0;
               snoozing <= 1'b0;
            end
            ARMED: begin
               if (match_rise_s) begin
                  state_r    <= RINGING;
                  ring       <= 1'b1;
                  snoozing   <= 1'b0;
                  ring_cnt_r <= RING_LOAD;
               end else begin
                  state_r  <= ARMED;
                  ring     <= 1'b0;
                  snoozing <= 1'b0;
               end
            end
            RINGING: begin
               if (stop) begin
                  state_r    <= ARMED;
                  ring       <= 1'b0;
                  ring_cnt_r <= RING_ZERO;
               end else if (snooze) begin
                  state_r    <= SNOOZE;
                  ring       <= 1'b0;
                  snoozing   <= 1'b1;
                  ring_cnt_r <= RING_ZERO;
                  snz_cnt_r  <= SNZ_LOAD;
               end else if (sec_tick && (ring_cnt_r == RING_ONE)) begin
                  state_r    <= ARMED;
                  ring       <= 1'b0;
                  ring_cnt_r <= RING_ZERO;
               end else if (sec_tick && (ring_cnt_r != RING_ZERO)) begin
                  ring_cnt_r <= ring_cnt_r - RING_ONE;
               end else begin
                  ring_cnt_r <= ring_cnt_r;
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_r   <= ARMED;
                  snoozing  <= 1'b0;
                  snz_cnt_r <= SNZ_ZERO;
               end else if (sec_tick && (snz_cnt_r == SNZ_ONE)) begin
                  state_r    <= RINGING;
                  ring       <= 1'b1;
                  snoozing   <= 1'b0;
                  snz_cnt_r  <= SNZ_ZERO;
                  ring_cnt_r <= RING_LOAD;
               end else if (sec_tick && (snz_cnt_r != SNZ_ZERO)) begin
                  snz_cnt_r <= snz_cnt_r - SNZ_ONE;
               end else begin
                  snz_cnt_r <= snz_cnt_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               ring       <= 1'b0;
               snoozing   <= 1'b0;
               ring_cnt_r <= RING_ZERO;
               snz_cnt_r  <= SNZ_ZERO;
            end
         endcase
      end
   end

endmodule

// File: doc/alarm_time_keeper.md
ALARM_TIME_KEEPER -- requirements
Module: alarm_time_keeper

Interface
REQ-001 The block SHALL have the following parameters:
- RING_SECS, 60, number of sec_tick pulses a ring lasts without user action.
- SNOOZE_SECS, 300, number of sec_tick pulses a snooze lasts.

REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hours  in  1  one-cycle pulse: increment alarm hour.
- mins  in  1  one-cycle pulse: increment alarm minute.
- alarm_en  in  1  level: alarm armed when high.
- stop  in  1  level/pulse: silence alarm.
- snooze  in  1  level/pulse: snooze alarm.
- sec_tick  in  1  one-cycle pulse per second.
- cur_hour  in  5  current time hour, 0..23.
- cur_min  in  6  current time minute, 0..59.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.
- ring  out  1  high while in RINGING.
- snoozing  out  1  high while in SNOOZE.

Function
REQ-003 hours pulse SHALL increment alarm_hour by 1, wrapping 23 -> 0, on the next rising edge.
REQ-004 mins pulse SHALL increment alarm_min by 1, wrapping 59 -> 0, with no carry into alarm_hour.
REQ-005 hours and mins high in the same cycle SHALL each apply independently in that cycle.
REQ-006 hours/mins SHALL be accepted in every state.
- A pulse while in RINGING or SNOOZE SHALL also move the FSM to ARMED (alarm cancelled).
REQ-007 match SHALL be (cur_hour == alarm_hour) && (cur_min == alarm_min).
- match_d SHALL be a registered copy of match, updated every cycle.
- match_rise SHALL be match && !match_d.
REQ-008 The FSM SHALL have four states: IDLE, ARMED, RINGING, SNOOZE; all outputs SHALL be registered.
REQ-009 alarm_en low in any state SHALL force IDLE on the next edge.
- This SHALL have the highest priority.
REQ-010 IDLE -> ARMED when alarm_en is high; match SHALL be ignored in IDLE.
REQ-011 ARMED -> RINGING on match_rise.
- ring_cnt SHALL load RING_SECS.
- ring SHALL be high the cycle after match_rise.
REQ-012 RINGING transitions, in priority order:
- stop -> ARMED.
- snooze -> SNOOZE, with snz_cnt loaded to SNOOZE_SECS.
- sec_tick with ring_cnt == 1 -> ARMED.
- otherwise sec_tick decrements ring_cnt.
REQ-013 SNOOZE transitions, in priority order:
- stop -> ARMED.
- sec_tick with snz_cnt == 1 -> RINGING, with ring_cnt reloaded to RING_SECS.
- otherwise sec_tick decrements snz_cnt.
- snooze SHALL be ignored in SNOOZE.
REQ-014 A return to ARMED SHALL NOT re-trigger until the next match_rise.
- In particular, a timeout within the same matching minute SHALL NOT re-ring.
REQ-015 ring_cnt and snz_cnt SHALL be sized to ceil(log2(param+1)) bits.
- Counters SHALL never underflow.
REQ-016 Editing the alarm to equal the current time while ARMED SHALL produce match_rise and ring.

Reset
REQ-017 While reset_n is low, asynchronously:
- alarm_hour = 0, alarm_min = 0.
- state = IDLE, ring = 0, snoozing = 0.
- ring_cnt = 0, snz_cnt = 0.
- match_d = 1.
REQ-018 Reset asserted mid-ring or mid-snooze SHALL clear all state immediately, with no residual ring after release.

Verification
REQ-019 Reset, then 25 hours pulses and 61 mins pulses -> alarm_hour = 1, alarm_min = 1.
REQ-020 Alarm 07:30, alarm_en = 1, cur_time stepped 07:29 -> 07:30 -> ring = 1 one cycle later.
- After 60 sec_ticks with no action -> ring = 0, state ARMED.
- Holding 07:30 -> no re-ring.
REQ-021 Ringing, snooze pulse -> ring = 0, snoozing = 1.
- After 300 sec_ticks -> ring = 1, snoozing = 0.
- Then stop -> ring = 0, ARMED.
REQ-022 Ringing, with stop and snooze high the same cycle -> ARMED (stop wins).
- Ringing, alarm_en dropped -> IDLE, ring = 0 next cycle.
REQ-023 Alarm 00:00 after reset, cur_time 00:00, alarm_en raised -> no ring.
- Then mins pulse with cur_min = 1 -> ring.
REQ-024 Reset_n pulsed low mid-snooze -> all outputs 0 asynchronously; ring stays 0 after release with alarm_en = 1.
